// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
// The requester side drives req/done; the arbiter side returns the grant.
interface rr_arbiter_4_if #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
);
   logic [NUM_REQ-1:0] req;
   logic               done;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid;
   logic               timeout;

   modport master (
      output req,
      output done,
      input  gnt,
      input  gnt_idx,
      input  gnt_valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output gnt,
      output gnt_idx,
      output gnt_valid,
      output timeout
   );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant and binary index.
// Define ARB_TIMEOUT_EN to force-release any grant held for MAX_HOLD cycles.
module rr_arbiter_4 #(
   parameter int NUM_REQ  = 4,
   parameter int IDX_W    = 2,
   parameter int MAX_HOLD = 8
) (
   input logic           clk,
   input logic           rst_n,
   rr_arbiter_4_if.slave bus
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [NUM_REQ-1:0] r_gnt;
   logic [IDX_W-1:0]   r_gntIdx;
   logic               r_gntValid;

   logic [IDX_W-1:0]   w_sel;
   logic [IDX_W-1:0]   w_scan;
   logic               w_found;
   logic               w_release;
   logic               w_expire;

   // Walk the scan order from farthest to nearest so the entry closest to ptr wins.
   always_comb begin
      w_sel   = r_ptr;
      w_scan  = r_ptr;
      w_found = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_scan = r_ptr + IDX_W'(k);
         if (bus.req[w_scan]) begin
            w_sel   = w_scan;
            w_found = 1'b1;
         end
      end
   end

   assign w_release = bus.done | ~bus.req[r_gntIdx];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] r_holdCnt;
   logic       r_timeout;

   assign w_expire    = (r_holdCnt == 8'(MAX_HOLD - 1));
   assign bus.timeout = r_timeout;
`else
   logic [7:0] w_unusedHold;

   assign w_unusedHold = 8'(MAX_HOLD);
   assign w_expire     = 1'b0;
   assign bus.timeout  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_gnt      <= '0;
         r_gntIdx   <= '0;
         r_gntValid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_holdCnt  <= '0;
         r_timeout  <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         r_timeout <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_state    <= GRANT;
                  r_gnt      <= NUM_REQ'(1) << w_sel;
                  r_gntIdx   <= w_sel;
                  r_gntValid <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  r_holdCnt  <= '0;
`endif
               end
            end
            GRANT: begin
               // A normal release wins over expiry, so timeout only flags forced drops.
               if (w_release || w_expire) begin
                  r_state    <= IDLE;
                  r_gnt      <= '0;
                  r_gntIdx   <= '0;
                  r_gntValid <= 1'b0;
                  r_ptr      <= r_gntIdx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
                  r_timeout  <= ~w_release;
`endif
               end
`ifdef ARB_TIMEOUT_EN
               else begin
                  r_holdCnt <= r_holdCnt + 8'd1;
               end
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_idx   = r_gntIdx;
   assign bus.gnt_valid = r_gntValid;

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Round-robin arbiter that shares one downstream resource among 4 requesters.
- Grants are one-hot. The granted index is also output in the team's 4-to-2 binary encoding (one-hot bit 0/1/2/3 -> 2'b00/01/10/11).
- A grant is held until the owner signals done or drops its request.
- Sits in front of shared datapath blocks so that exactly one requester drives them at a time.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 for this revision.
- IDX_W, 2, width of the encoded grant index.
- MAX_HOLD, 8, maximum cycles a grant may be held; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  4  request vector; bit i = requester i; level-sensitive.
- done  input  1  owner finished; sampled only in GRANT.
- gnt  output  4  one-hot grant; all zero when no grant.
- gnt_idx  output  2  binary index of the granted requester; 2'b00 when gnt_valid=0.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on forced release; constant 0 when ARB_TIMEOUT_EN is not defined.

Behaviour:
- Clock and reset:
  - Single clock domain, all outputs registered.
  - Reset is synchronous: rst_n=0 sampled at a rising edge forces state=IDLE, ptr=2'b00, gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0, timeout=0, hold_cnt=0.
  - Reset mid-grant drops the grant on that same edge. No release bookkeeping is done and ptr returns to 0.
- ptr: 2-bit next-highest-priority requester. The priority scan order is ptr, ptr+1, ptr+2, ptr+3, with mod-4 wrap.
- State IDLE:
  - If req != 0, select the first set bit in scan order.
  - Next edge: state=GRANT, gnt=onehot(sel), gnt_idx=sel, gnt_valid=1.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req==0, remain in IDLE with outputs at 0.
- State GRANT, owner o:
  - Hold while req[o]=1 and done=0. gnt stays stable and changes in other req bits are ignored.
  - Release occurs when done=1, or req[o]=0, or on timeout (optional feature). Both done=1 and req[o]=0 in the same cycle count as a single release.
  - On a release edge: state=IDLE, gnt=0, gnt_valid=0, gnt_idx=0, ptr=(o+1) mod 4. Wrap rule: o=3 gives ptr=0.
  - There is always exactly one dead cycle (gnt=0) between consecutive grants. The next grant appears 2 cycles after the release condition is sampled.
- done in IDLE is ignored.
- A non-onehot gnt is illegal and must never occur. gnt_idx always equals the 4-to-2 encoding of gnt.
- Simultaneous requests are resolved only by ptr; no requester starves. Under continuous 4-way contention each requester is granted once every 4 grants.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - hold_cnt (8-bit) clears on grant and increments each GRANT cycle.
  - When hold_cnt==MAX_HOLD-1 and no other release condition is present in that cycle, the grant is force-released (same edge effects as a normal release, ptr advances) and timeout=1 for exactly one cycle, coincident with gnt going to 0.
  - A normal release in the same cycle takes precedence and produces timeout=0.
  - Grant duration never exceeds MAX_HOLD cycles.
- Not defined: no counter exists, timeout is tied 0, and a grant can be held indefinitely.

Test Plan:
1. Reset check: hold rst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, gnt_idx=0, gnt_valid=0. Release reset -> the next edge gives gnt=4'b0001, gnt_idx=2'b00.
2. Round-robin rotation: req=4'b1111 held, pulse done 1 cycle per grant -> grant sequence is 0001, 1000? no: 0001, 0010, 0100, 1000, 0001 (gnt_idx 00, 01, 10, 11, 00), with one gnt=0 cycle between each.
3. Wrap and skip: owner=3 released with req=4'b0101 -> ptr=0 and the next grant is 0001. After releasing requester 0 with req=4'b0100 -> the next grant is 0100, gnt_idx=10.
4. Request drop: owner 1 granted, then req[1] deasserts with done=0 -> gnt=0 on the next edge and ptr=2. Other req bits changing during GRANT cause no gnt change.
5. Mid-grant reset: owner 2 granted, rst_n=0 for 1 cycle -> gnt=0 on that edge. With req=4'b1111 afterwards the next grant is 0001 (ptr reset to 0).
6. Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req=4'b0011 held, done=0 -> requester 0 is granted for exactly 8 cycles, then timeout=1 for 1 cycle with gnt=0, then gnt=0010. Same stimulus without the macro -> gnt=0001 held indefinitely and timeout stays 0.
